// File: rtl/hamming74_uart_tx.sv
// Hamming(7,4) encoder feeding a UART serialiser: start(0), 7 code bits LSB-first, [parity], stop(1).
// Define HAMMING74_TX_PARITY_EN to insert an even-parity bit (over the 7 code bits) before stop.
module hamming74_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [6:0] code_out
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [6:0]      shift_q, shift_d;
  logic [6:0]      code_q, code_d;
  logic            tx_q, tx_d;
  logic [6:0]      code_in;
  logic            accept;
  logic            wrap;

  assign code_in = {data_in[3], data_in[2], data_in[1],
                    data_in[1] ^ data_in[2] ^ data_in[3],
                    data_in[0],
                    data_in[0] ^ data_in[2] ^ data_in[3],
                    data_in[0] ^ data_in[1] ^ data_in[3]};
  assign accept  = data_valid & data_ready;
  assign wrap    = (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      code_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      code_q  <= code_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        S_IDLE:   if (accept) state_d = S_START;
        S_START:  if (wrap) state_d = S_DATA;
        S_DATA: begin
          if (wrap && idx_q == 3'd6) begin
`ifdef HAMMING74_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
        S_PARITY: if (wrap) state_d = S_STOP;
        S_STOP:   if (wrap) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // tx_d is the line value for the state being entered, so tx stays a pure flop output
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    code_d  = code_q;
    tx_d    = tx_q;
    if (ena) begin
      if (state_q == S_IDLE) begin
        cnt_d = '0;
        idx_d = '0;
        tx_d  = 1'b1;
        if (accept) begin
          code_d  = code_in;
          shift_d = code_in;
          tx_d    = 1'b0;
        end
      end else begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (wrap) begin
          case (state_q)
            S_START: tx_d = shift_q[0];
            S_DATA: begin
              if (idx_q == 3'd6) begin
                idx_d = '0;
`ifdef HAMMING74_TX_PARITY_EN
                tx_d  = ^code_q;
`else
                tx_d  = 1'b1;
`endif
              end else begin
                idx_d   = idx_q + 3'd1;
                shift_d = shift_q >> 1;
                tx_d    = shift_q[1];
              end
            end
            default: tx_d = 1'b1;
          endcase
        end
      end
    end
  end

  always_comb begin
    data_ready = ena & (state_q == S_IDLE) & ~rst;
    busy       = (state_q != S_IDLE);
    done       = ena & (state_q == S_STOP) & wrap;
    tx         = tx_q;
    code_out   = code_q;
  end
endmodule

// File: tb/tb_hamming74_uart_tx.sv
// Bench for hamming74_uart_tx: directed and random frames checked against a positional Hamming model and a mid-bit sampling receiver.
module tb_hamming74_uart_tx;
  localparam int CPB = 4;
`ifdef HAMMING74_TX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst, ena, data_valid;
  logic [3:0] data_in;
  logic       data_ready, tx, busy, done;
  logic [6:0] code_out;

  int n_checks = 0;
  int n_fail   = 0;

  hamming74_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx(tx), .busy(busy), .done(done), .code_out(code_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Codeword built by Hamming position: data at 3,5,6,7, parity bit 2^p covers positions with bit p set
  function automatic logic [6:0] ref_code(input logic [3:0] d);
    logic [7:1] w;
    logic       par;
    w    = '0;
    w[3] = d[0];
    w[5] = d[1];
    w[6] = d[2];
    w[7] = d[3];
    for (int p = 0; p < 3; p++) begin
      par = 1'b0;
      for (int k = 1; k <= 7; k++)
        if ((k & (1 << p)) != 0) par ^= w[k];
      w[1 << p] = par;
    end
    return w[7:1];
  endfunction

  function automatic int syndrome(input logic [6:0] c);
    int s;
    s = 0;
    for (int k = 1; k <= 7; k++)
      if (c[k-1]) s ^= k;
    return s;
  endfunction

  task automatic frame(input logic [3:0] nib, input int frz_at, input int frz_len,
                       input int abort_at, input bit keep_valid, input logic [3:0] next_nib);
    logic [6:0]       c;
    logic             bits [NBITS];
    logic [NBITS-1:0] rx;
    logic [6:0]       rc;
    int               j, frz, w, cyc;
    c = ref_code(nib);
    bits[0] = 1'b0;
    for (int k = 0; k < 7; k++) bits[k+1] = c[k];
`ifdef HAMMING74_TX_PARITY_EN
    bits[8] = ^c;
`endif
    bits[NBITS-1] = 1'b1;

    data_in    = nib;
    data_valid = 1'b1;
    w = 0;
    while (data_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_before_accept", data_ready, 1);
    @(posedge clk); #1;
    data_valid = keep_valid;
    data_in    = next_nib;
    check("code_out_latch", code_out, c);

    j = 0; frz = 0; cyc = 0; rx = '0;
    while (j < FLEN) begin
      if (j == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ready", data_ready, 0);
        rst = 1'b0;
        data_valid = 1'b0;
        return;
      end
      ena = !(j == frz_at && frz < frz_len);
      if (!ena) frz++;
      #1;
      check("tx_bit", tx, bits[j / CPB]);
      check("busy_frame", busy, 1);
      check("done_pulse", done, (ena && j == FLEN - 1));
      check("ready_busy", data_ready, 0);
      check("code_hold", code_out, c);
      if (ena && (j % CPB) == CPB / 2) rx[j / CPB] = tx;
      if (ena) j++;
      cyc++;
      @(posedge clk); #1;
    end
    ena = 1'b1;
    check("frame_cycles", cyc, FLEN + frz_len);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);
    check("idle_ready", data_ready, 1);

    rc = rx[7:1];
    check("rx_start", rx[0], 0);
    check("rx_stop", rx[NBITS-1], 1);
    check("rx_syndrome", syndrome(rc), 0);
    check("rx_data", {rc[6], rc[5], rc[4], rc[2]}, nib);
`ifdef HAMMING74_TX_PARITY_EN
    check("rx_parity", rx[8], ^rc);
`endif
  endtask

  initial begin
    logic [3:0] r;
    int         off;
    rst = 1'b1; ena = 1'b1; data_valid = 1'b1; data_in = 4'h5;

    // reset, with valid asserted to confirm reset wins over accept
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_code", code_out, 0);
      check("rst_ready", data_ready, 0);
    end
    rst = 1'b0;
    data_valid = 1'b0;
    #1;
    check("ready_after_rst", data_ready, 1);

    // directed nibble 1011 -> 0x55
    frame(4'b1011, -1, 0, -1, 1'b0, 4'h0);
    check("code_0x55", code_out, 7'h55);

    // back-to-back: 0xF with valid held into 0x0
    frame(4'hF, -1, 0, -1, 1'b1, 4'h0);
    check("code_0x7f", code_out, 7'h7F);
    frame(4'h0, -1, 0, -1, 1'b0, 4'h0);
    check("code_0x00", code_out, 7'h00);

    // enable dropped for 10 cycles during code bit 3
    r = 4'($urandom_range(0, 15));
    frame(r, 4 * CPB + 1, 10, -1, 1'b0, 4'h0);

    // reset mid data phase, then a fresh frame
    r = 4'($urandom_range(0, 15));
    frame(r, -1, 0, 3 * CPB + 2, 1'b0, 4'h0);
    r = 4'($urandom_range(0, 15));
    frame(r, -1, 0, -1, 1'b0, 4'h0);

    // every nibble, starting at a random offset
    off = int'($urandom_range(0, 15));
    for (int i = 0; i < 16; i++)
      frame(4'((i + off) & 15), -1, 0, -1, 1'b0, 4'h0);

    // random nibbles with random freeze points
    for (int i = 0; i < 6; i++) begin
      r = 4'($urandom_range(0, 15));
      frame(r, int'($urandom_range(0, FLEN - 1)), int'($urandom_range(1, 5)),
            -1, 1'b0, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
